// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, operator
// encoding, special key codes and the lowest-set-row helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_EQ   = 2'd3
    } op_e;

    localparam int unsigned KEY_ADD    = 10;
    localparam int unsigned KEY_SUB    = 11;
    localparam int unsigned KEY_EQ     = 12;
    localparam int unsigned NUM_LIMIT  = 10;
    localparam int unsigned FIFO_DEPTH = 4;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_lut.sv
// Combinational decode of the head key code into digit/operator class.
// All outputs are forced low while no event is present.
module keypad_lut
    import keypad_pkg::*;
#(
    parameter int unsigned KW = 4
) (
    input  logic          valid_i,
    input  logic [KW-1:0] code_i,
    output logic          is_num_o,
    output logic          is_op_o,
    output logic [1:0]    which_op_o
);

    int unsigned code_u;

    always_comb begin
        code_u     = 32'(code_i);
        is_num_o   = 1'b0;
        is_op_o    = 1'b0;
        which_op_o = OP_NONE;
        if (valid_i) begin
            is_num_o = (code_u < NUM_LIMIT);
            if (code_u == KEY_ADD) begin
                is_op_o    = 1'b1;
                which_op_o = OP_ADD;
            end else if (code_u == KEY_SUB) begin
                is_op_o    = 1'b1;
                which_op_o = OP_SUB;
            end else if (code_u == KEY_EQ) begin
                is_op_o    = 1'b1;
                which_op_o = OP_EQ;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, press/release debounce, event storage
// with valid/ready handshake. KEYPAD_SCANNER_FIFO_EN selects a 4-entry FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_CYCLES     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    localparam int unsigned KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] rows,
    output logic [COLS-1:0] cols,
    input  logic            key_ready,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic            is_num,
    output logic            is_op,
    output logic [1:0]      which_op,
    output logic            overflow
);

    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CB    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned MAXC  = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAXC);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CB-1:0]    COL_LAST  = CB'(COLS - 1);

    logic [ROWS-1:0]  rows_s1_q, rows_s2_q;
    state_e           state_q, state_d;
    logic [CB-1:0]    col_q, col_d, next_col;
    logic [RW-1:0]    row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             row_hit;
    logic             push;
    logic [KW-1:0]    push_code;
    logic             pop, accept, drop;
    logic [KW-1:0]    head_code;
    logic             overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_s1_q <= '0;
            rows_s2_q <= '0;
        end else begin
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
        end
    end

    assign row_hit   = rows_s2_q[row_q];
    assign next_col  = (col_q == COL_LAST) ? '0 : col_q + CB'(1);
    assign push_code = KW'(32'(row_q) * COLS + 32'(col_q));

    always_comb begin
        cols        = '0;
        cols[col_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (|rows_s2_q) begin
                        row_d   = RW'(lowest_set(8'(rows_s2_q)));
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = next_col;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!row_hit) begin
                    state_d = SCAN;
                    col_d   = next_col;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    push    = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (row_hit) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    col_d   = next_col;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

`ifdef KEYPAD_SCANNER_FIFO_EN
    logic [KW-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic          full;

    assign key_valid = (count_q != '0);
    assign full      = (count_q == 3'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign head_code = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic          hold_valid_q;
    logic [KW-1:0] hold_code_q;

    assign key_valid = hold_valid_q;
    assign pop       = hold_valid_q && key_ready;
    assign accept    = push && (!hold_valid_q || pop);
    assign drop      = push && hold_valid_q && !pop;
    assign head_code = hold_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_code_q  <= '0;
        end else if (accept) begin
            hold_valid_q <= 1'b1;
            hold_code_q  <= push_code;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
    assign key_code = key_valid ? head_code : '0;

    keypad_lut #(
        .KW(KW)
    ) u_lut (
        .valid_i    (key_valid),
        .code_i     (key_code),
        .is_num_o   (is_num),
        .is_op_o    (is_op),
        .which_op_o (which_op)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical key-matrix model drives
// rows from cols, and a scoreboard checks events against the keypad rules.
module tb_keypad_scanner;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int SCAN    = 4;
    localparam int DEB     = 5;
    localparam int LAT_MAX = 2 + COLS * SCAN + DEB + 1;
`ifdef KEYPAD_SCANNER_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] rows;
    logic [COLS-1:0] cols;
    logic            key_ready = 1'b1;
    logic            key_valid;
    logic [3:0]      key_code;
    logic            is_num, is_op;
    logic [1:0]      which_op;
    logic            overflow;

    logic [ROWS*COLS-1:0] pressed = '0;
    int checks = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        int code;
        bit num;
        bit op;
        int wop;
        int cyc;
    } ev_t;
    ev_t got[$];

    keypad_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_CYCLES(SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rows(rows),
        .cols(cols),
        .key_ready(key_ready),
        .key_valid(key_valid),
        .key_code(key_code),
        .is_num(is_num),
        .is_op(is_op),
        .which_op(which_op),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to its column while that column is driven.
    always_comb begin
        rows = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r*COLS+c] && cols[c]) rows[r] = 1'b1;
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && key_valid && key_ready)
            got.push_back('{int'(key_code), is_num, is_op, int'(which_op), cyc});
    end

    function automatic bit exp_num(int code);
        return code < 10;
    endfunction
    function automatic bit exp_op(int code);
        return code >= 10 && code <= 12;
    endfunction
    function automatic int exp_wop(int code);
        return exp_op(code) ? code - 9 : 0;
    endfunction

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_key(int code, int hold, int idle, output int press_cyc);
        pressed[code] = 1'b1;
        press_cyc = cyc;
        cycles(hold);
        pressed[code] = 1'b0;
        cycles(idle);
    endtask

    // Returns at the first negedge after column c becomes driven.
    task automatic wait_col_start(int c, output bit ok);
        int n = 0;
        while (cols[c] && n < 100) begin @(negedge clk); n++; end
        while (!cols[c] && n < 100) begin @(negedge clk); n++; end
        ok = cols[c];
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_ready = 1'b1; pressed = '0;
        cycles(3);
        checks++; if (cols !== 4'b0001) $display("FAIL reset_cols: got %b expected 0001", cols); else passes++;
        checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", key_valid); else passes++;
        checks++; if (key_code !== 4'd0) $display("FAIL reset_code: got %0d expected 0", key_code); else passes++;
        checks++; if ({is_num, is_op, which_op} !== 4'b0) $display("FAIL reset_decode: got %b expected 0000", {is_num, is_op, which_op}); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
        rst_n = 1'b1;
        cycles(2);
        checks++; if (cols !== 4'b0001) $display("FAIL post_reset_cols: got %b expected 0001", cols); else passes++;
    endtask

    task automatic test_single_press();
        int p;
        got.delete();
        hold_key(6, 40, 20, p);
        checks++; if (got.size() != 1) $display("FAIL single_count: got %0d expected 1", got.size()); else passes++;
        if (got.size() >= 1) begin
            checks++; if (got[0].code != 6) $display("FAIL single_code: got %0d expected 6", got[0].code); else passes++;
            checks++; if ({got[0].num, got[0].op} != 2'b10) $display("FAIL single_class: got %b expected 10", {got[0].num, got[0].op}); else passes++;
            checks++; if (got[0].wop != 0) $display("FAIL single_wop: got %0d expected 0", got[0].wop); else passes++;
            checks++; if (got[0].cyc - p > LAT_MAX) $display("FAIL single_latency: got %0d expected <= %0d", got[0].cyc - p, LAT_MAX); else passes++;
        end
    endtask

    task automatic test_op_key();
        int p;
        got.delete();
        hold_key(11, 100, 20, p);
        checks++; if (got.size() != 1) $display("FAIL op_count: got %0d expected 1", got.size()); else passes++;
        if (got.size() >= 1) begin
            checks++; if (got[0].code != 11) $display("FAIL op_code: got %0d expected 11", got[0].code); else passes++;
            checks++; if ({got[0].num, got[0].op} != 2'b01) $display("FAIL op_class: got %b expected 01", {got[0].num, got[0].op}); else passes++;
            checks++; if (got[0].wop != 2) $display("FAIL op_wop: got %0d expected 2", got[0].wop); else passes++;
        end
    endtask

    task automatic test_random_presses();
        int codes[$];
        int pcyc[$];
        int p, c;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            c = int'($urandom_range(0, ROWS*COLS-1));
            codes.push_back(c);
            hold_key(c, int'($urandom_range(30, 60)), 15, p);
            pcyc.push_back(p);
        end
        checks++; if (got.size() != codes.size()) $display("FAIL rand_count: got %0d expected %0d", got.size(), codes.size()); else passes++;
        for (int i = 0; i < codes.size() && i < got.size(); i++) begin
            checks++; if (got[i].code != codes[i]) $display("FAIL rand_code[%0d]: got %0d expected %0d", i, got[i].code, codes[i]); else passes++;
            checks++;
            if (got[i].num != exp_num(codes[i]) || got[i].op != exp_op(codes[i]) || got[i].wop != exp_wop(codes[i]))
                $display("FAIL rand_decode[%0d]: got num=%0d op=%0d wop=%0d expected num=%0d op=%0d wop=%0d", i,
                         got[i].num, got[i].op, got[i].wop, exp_num(codes[i]), exp_op(codes[i]), exp_wop(codes[i]));
            else passes++;
            checks++; if (got[i].cyc - pcyc[i] > LAT_MAX) $display("FAIL rand_latency[%0d]: got %0d expected <= %0d", i, got[i].cyc - pcyc[i], LAT_MAX); else passes++;
        end
    endtask

    task automatic test_bounce();
        bit ok;
        int p;
        got.delete();
        wait_col_start(2, ok);
        checks++; if (!ok) $display("FAIL bounce_col_wait: got timeout expected column 2"); else passes++;
        pressed[2] = 1'b1; cycles(3);
        pressed[2] = 1'b0; cycles(1);
        pressed[2] = 1'b1; cycles(3);
        pressed[2] = 1'b0; cycles(30);
        checks++; if (got.size() != 0) $display("FAIL bounce_no_event: got %0d expected 0", got.size()); else passes++;
        wait_col_start(2, ok);
        hold_key(2, 10, 15, p);
        checks++; if (got.size() != 1) $display("FAIL bounce_held_count: got %0d expected 1", got.size()); else passes++;
        if (got.size() >= 1) begin
            checks++; if (got[0].code != 2) $display("FAIL bounce_held_code: got %0d expected 2", got[0].code); else passes++;
        end
    endtask

    task automatic test_backpressure();
        int codes[$];
        int c, p;
        bit dup;
        got.delete();
        key_ready = 1'b0;
        while (codes.size() < 5) begin
            c = int'($urandom_range(0, ROWS*COLS-1));
            dup = 1'b0;
            foreach (codes[j]) if (codes[j] == c) dup = 1'b1;
            if (!dup) codes.push_back(c);
        end
        foreach (codes[i]) hold_key(codes[i], 40, 15, p);
        checks++; if (key_valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", key_valid); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b expected 1", overflow); else passes++;
        checks++; if (int'(key_code) != codes[0]) $display("FAIL bp_head_code: got %0d expected %0d", key_code, codes[0]); else passes++;
        key_ready = 1'b1;
        cycles(10);
        checks++; if (got.size() != DEPTH) $display("FAIL bp_drain_count: got %0d expected %0d", got.size(), DEPTH); else passes++;
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            checks++; if (got[i].code != codes[i]) $display("FAIL bp_drain_code[%0d]: got %0d expected %0d", i, got[i].code, codes[i]); else passes++;
        end
        checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); else passes++;
        pulse_reset();
        checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_cleared: got %b expected 0", overflow); else passes++;
    endtask

    task automatic test_reset_mid_debounce();
        bit ok;
        int p;
        got.delete();
        key_ready = 1'b1;
        wait_col_start(1, ok);
        checks++; if (!ok) $display("FAIL rst_col_wait: got timeout expected column 1"); else passes++;
        pressed[5] = 1'b1;
        cycles(6);
        rst_n = 1'b0;
        pressed[5] = 1'b0;
        cycles(1);
        checks++; if (cols !== 4'b0001) $display("FAIL rst_mid_cols: got %b expected 0001", cols); else passes++;
        checks++; if (key_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", key_valid); else passes++;
        cycles(2);
        rst_n = 1'b1;
        cycles(60);
        checks++; if (got.size() != 0) $display("FAIL rst_mid_no_event: got %0d expected 0", got.size()); else passes++;
        hold_key(5, 40, 15, p);
        checks++; if (got.size() != 1 || got[0].code != 5) $display("FAIL rst_fresh_press: got count %0d expected 1 event code 5", got.size()); else passes++;

        got.delete();
        key_ready = 1'b0;
        hold_key(9, 40, 15, p);
        checks++; if (key_valid !== 1'b1) $display("FAIL rst_hs_pending: got %b expected 1", key_valid); else passes++;
        rst_n = 1'b0;
        cycles(1);
        checks++; if (key_valid !== 1'b0) $display("FAIL rst_hs_valid: got %b expected 0", key_valid); else passes++;
        rst_n = 1'b1;
        key_ready = 1'b1;
        cycles(40);
        checks++; if (got.size() != 0) $display("FAIL rst_hs_no_event: got %0d expected 0", got.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        int codes[$];
        int p, last;
        bit ok;
        pulse_reset();
        got.delete();
        key_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) codes.push_back(i * 3);
        last = 13;
        codes.push_back(last);
        for (int i = 0; i < DEPTH; i++) hold_key(codes[i], 40, 15, p);
        wait_col_start(last % COLS, ok);
        checks++; if (!ok) $display("FAIL b2b_col_wait: got timeout expected column %0d", last % COLS); else passes++;
        // Press aligned to the column start: push lands on the 9th clock edge.
        pressed[last] = 1'b1;
        cycles(8);
        key_ready = 1'b1;
        cycles(1);
        key_ready = 1'b0;
        cycles(20);
        pressed[last] = 1'b0;
        cycles(15);
        checks++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b expected 0", overflow); else passes++;
        checks++; if (key_valid !== 1'b1) $display("FAIL b2b_still_full: got %b expected 1", key_valid); else passes++;
        key_ready = 1'b1;
        cycles(10);
        checks++; if (got.size() != DEPTH + 1) $display("FAIL b2b_count: got %0d expected %0d", got.size(), DEPTH + 1); else passes++;
        for (int i = 0; i < DEPTH + 1 && i < got.size(); i++) begin
            checks++; if (got[i].code != codes[i]) $display("FAIL b2b_code[%0d]: got %0d expected %0d", i, got[i].code, codes[i]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_op_key();
        test_random_presses();
        test_bounce();
        test_backpressure();
        test_reset_mid_debounce();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
